// File: rtl/axi_mon_id_alloc.sv
// rtl/axi_mon_id_alloc.sv - AXI monitor master-ID to internal-slot allocator
//
// Maps each master ID seen on a monitored AW or AR channel onto an internal slot.
// Tracks the number of outstanding transactions per slot. Frees a slot once its
// last transaction completes. The response path uses the reverse lookup.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i, req_id_i  request observed on the bus and its master ID
//   req_ready_o            the request can be tracked this cycle (independent of req_valid_i)
//   req_intid_o            granted slot (0 when req_ready_o=0)
//   cpl_valid_i            completion (last B / last R) observed
//   cpl_intid_i            slot of the completing transaction
//   cpl_id_o               master ID stored in slot cpl_intid_i
//   cpl_err_o              one-cycle pulse: the completion hit an empty or out-of-range slot
//   full_o, empty_o        all slots valid / no slot valid
module axi_mon_id_alloc #(
  parameter int MaxUniqIds   = 4,
  parameter int MaxTxnsPerId = 256,
  parameter int IdWidth      = 2,
  parameter int IntIdWidth   = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1,
  parameter int CntW         = $clog2(MaxTxnsPerId + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [IdWidth-1:0]    req_id_i,
  output logic                  req_ready_o,
  output logic [IntIdWidth-1:0] req_intid_o,
  input  logic                  cpl_valid_i,
  input  logic [IntIdWidth-1:0] cpl_intid_i,
  output logic [IdWidth-1:0]    cpl_id_o,
  output logic                  cpl_err_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [MaxUniqIds-1:0] valid_q;
  logic [IdWidth-1:0]    id_q  [MaxUniqIds];
  logic [CntW-1:0]       cnt_q [MaxUniqIds];
  logic                  cpl_err_q;

  logic                  hit;
  logic [IntIdWidth-1:0] hit_idx;
  logic [CntW-1:0]       hit_cnt;
  logic                  free_found;
  logic [IntIdWidth-1:0] free_idx;
  logic [MaxUniqIds-1:0] acc_vec;
  logic [MaxUniqIds-1:0] cpl_vec;

  // Request lookup over registered state only. IDs are unique across valid slots,
  // so at most one slot can hit.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_cnt    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      if (valid_q[i] && (id_q[i] == req_id_i)) begin
        hit     = 1'b1;
        hit_idx = IntIdWidth'(i);
        hit_cnt = cnt_q[i];
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IntIdWidth'(i);
      end
    end
  end

  always_comb begin
    req_ready_o = hit ? (hit_cnt < CntW'(MaxTxnsPerId)) : free_found;
    req_intid_o = '0;
    if (req_ready_o) begin
      req_intid_o = hit ? hit_idx : free_idx;
    end
  end

  // Per-slot strobes. A completion only counts when it targets a valid slot.
  // Indices at or above MaxUniqIds match no slot and so raise cpl_err.
  always_comb begin
    acc_vec  = '0;
    cpl_vec  = '0;
    cpl_id_o = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      acc_vec[i] = req_valid_i && req_ready_o && (req_intid_o == IntIdWidth'(i));
      cpl_vec[i] = cpl_valid_i && valid_q[i] && (cpl_intid_i == IntIdWidth'(i));
      if (cpl_intid_i == IntIdWidth'(i)) begin
        cpl_id_o = id_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      cpl_err_q <= 1'b0;
      for (int i = 0; i < MaxUniqIds; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      cpl_err_q <= cpl_valid_i && (cpl_vec == '0);
      for (int i = 0; i < MaxUniqIds; i++) begin
        // An accept and a completion on the same slot cancel out.
        // That slot is necessarily valid, so it stays valid even at cnt==1.
        if (acc_vec[i] && !cpl_vec[i]) begin
          if (valid_q[i]) begin
            cnt_q[i] <= cnt_q[i] + CntW'(1);
          end else begin
            valid_q[i] <= 1'b1;
            id_q[i]    <= req_id_i;
            cnt_q[i]   <= CntW'(1);
          end
        end else if (cpl_vec[i] && !acc_vec[i]) begin
          cnt_q[i] <= cnt_q[i] - CntW'(1);
          if (cnt_q[i] == CntW'(1)) begin
            valid_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign cpl_err_o = cpl_err_q;
  assign full_o    = &valid_q;
  assign empty_o   = ~|valid_q;

endmodule

// File: tb/tb_axi_mon_id_alloc.sv
// tb/tb_axi_mon_id_alloc.sv - directed self-checking bench for axi_mon_id_alloc
module tb_axi_mon_id_alloc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Instance a: default parameters (IdWidth=2)
  logic       a_rst, a_req_valid, a_req_ready, a_cpl_valid, a_cpl_err, a_full, a_empty;
  logic [1:0] a_req_id, a_req_intid, a_cpl_intid, a_cpl_id;

  axi_mon_id_alloc dut_a (
    .clk_i(clk), .rst_i(a_rst),
    .req_valid_i(a_req_valid), .req_id_i(a_req_id),
    .req_ready_o(a_req_ready), .req_intid_o(a_req_intid),
    .cpl_valid_i(a_cpl_valid), .cpl_intid_i(a_cpl_intid),
    .cpl_id_o(a_cpl_id), .cpl_err_o(a_cpl_err),
    .full_o(a_full), .empty_o(a_empty)
  );

  // Instance b: IdWidth=3, so an unseen ID can arrive while all slots are full
  logic       b_rst, b_req_valid, b_req_ready, b_cpl_valid, b_cpl_err, b_full, b_empty;
  logic [2:0] b_req_id, b_cpl_id;
  logic [1:0] b_req_intid, b_cpl_intid;

  axi_mon_id_alloc #(.IdWidth(3)) dut_b (
    .clk_i(clk), .rst_i(b_rst),
    .req_valid_i(b_req_valid), .req_id_i(b_req_id),
    .req_ready_o(b_req_ready), .req_intid_o(b_req_intid),
    .cpl_valid_i(b_cpl_valid), .cpl_intid_i(b_cpl_intid),
    .cpl_id_o(b_cpl_id), .cpl_err_o(b_cpl_err),
    .full_o(b_full), .empty_o(b_empty)
  );

  // Advance one clock; inputs are driven 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic rv, input logic [1:0] rid, input logic cv, input logic [1:0] cid);
    a_req_valid = rv; a_req_id = rid; a_cpl_valid = cv; a_cpl_intid = cid;
    #1;
  endtask

  task automatic a_reset();
    a_rst = 1'b1;
    a_drive(1'b0, 2'd0, 1'b0, 2'd0);
    cycle();
    a_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    a_reset();
    total_cnt++; if (a_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", a_empty); else pass_cnt++;
    total_cnt++; if (a_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", a_full); else pass_cnt++;
    total_cnt++; if (a_cpl_err !== 1'b0) $display("FAIL reset_cpl_err got=%b exp=0", a_cpl_err); else pass_cnt++;
  endtask

  task automatic test_first_alloc();
    a_reset();
    a_drive(1'b1, 2'd2, 1'b0, 2'd0);
    total_cnt++; if ({a_req_ready, a_req_intid} !== 3'b1_00) $display("FAIL first_grant got=%b/%0d exp=1/0", a_req_ready, a_req_intid); else pass_cnt++;
    cycle();
    a_drive(1'b0, 2'd2, 1'b0, 2'd0);
    total_cnt++; if (a_empty !== 1'b0) $display("FAIL first_empty got=%b exp=0", a_empty); else pass_cnt++;
    total_cnt++; if (a_cpl_id !== 2'd2) $display("FAIL first_cpl_id got=%0d exp=2", a_cpl_id); else pass_cnt++;
    // cnt must be exactly 1: a single completion empties the allocator
    a_drive(1'b0, 2'd0, 1'b1, 2'd0);
    cycle();
    a_drive(1'b0, 2'd0, 1'b0, 2'd0);
    total_cnt++; if (a_empty !== 1'b1) $display("FAIL first_cnt_one got_empty=%b exp=1", a_empty); else pass_cnt++;
  endtask

  task automatic test_fill();
    a_reset();
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b1, 2'(i), 1'b0, 2'd0);
      total_cnt++; if ({a_req_ready, a_req_intid} !== {1'b1, 2'(i)}) $display("FAIL fill_grant%0d got=%b/%0d exp=1/%0d", i, a_req_ready, a_req_intid, i); else pass_cnt++;
      cycle();
    end
    a_drive(1'b0, 2'd1, 1'b0, 2'd3);
    total_cnt++; if (a_full !== 1'b1) $display("FAIL fill_full got=%b exp=1", a_full); else pass_cnt++;
    total_cnt++; if ({a_req_ready, a_req_intid} !== 3'b1_01) $display("FAIL fill_hit got=%b/%0d exp=1/1", a_req_ready, a_req_intid); else pass_cnt++;
    total_cnt++; if (a_cpl_id !== 2'd3) $display("FAIL fill_cpl_id got=%0d exp=3", a_cpl_id); else pass_cnt++;
  endtask

  task automatic test_saturate();
    int bad = 0;
    a_reset();
    for (int i = 0; i < 256; i++) begin
      a_drive(1'b1, 2'd1, 1'b0, 2'd0);
      if (a_req_ready !== 1'b1 || a_req_intid !== 2'd0) bad++;
      cycle();
    end
    total_cnt++; if (bad != 0) $display("FAIL sat_accept_256 bad_cycles=%0d exp=0", bad); else pass_cnt++;
    // 257th request is refused; hold req_valid high to catch a spurious increment
    a_drive(1'b1, 2'd1, 1'b0, 2'd0);
    total_cnt++; if ({a_req_ready, a_req_intid} !== 3'b0_00) $display("FAIL sat_refuse got=%b/%0d exp=0/0", a_req_ready, a_req_intid); else pass_cnt++;
    cycle();
    a_drive(1'b0, 2'd1, 1'b1, 2'd0);
    cycle();
    a_drive(1'b0, 2'd1, 1'b0, 2'd0);
    total_cnt++; if ({a_req_ready, a_req_intid} !== 3'b1_00) $display("FAIL sat_after_cpl got=%b/%0d exp=1/0", a_req_ready, a_req_intid); else pass_cnt++;
    a_drive(1'b1, 2'd1, 1'b0, 2'd0);
    cycle();
    a_drive(1'b0, 2'd1, 1'b0, 2'd0);
    total_cnt++; if (a_req_ready !== 1'b0) $display("FAIL sat_refill got=%b exp=0", a_req_ready); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    a_reset();
    a_drive(1'b1, 2'd0, 1'b0, 2'd0); cycle();
    a_drive(1'b1, 2'd3, 1'b0, 2'd0); cycle();
    // slot1 holds id 3 with cnt 1: accept and complete on it together
    a_drive(1'b1, 2'd3, 1'b1, 2'd1);
    total_cnt++; if ({a_req_ready, a_req_intid} !== 3'b1_01) $display("FAIL same_grant got=%b/%0d exp=1/1", a_req_ready, a_req_intid); else pass_cnt++;
    cycle();
    a_drive(1'b0, 2'd2, 1'b0, 2'd1);
    total_cnt++; if (a_req_intid !== 2'd2) $display("FAIL same_still_valid got_intid=%0d exp=2", a_req_intid); else pass_cnt++;
    total_cnt++; if (a_cpl_id !== 2'd3) $display("FAIL same_cpl_id got=%0d exp=3", a_cpl_id); else pass_cnt++;
    // completion frees slot1 while a new id misses: it must not get slot1 this cycle
    a_drive(1'b1, 2'd2, 1'b1, 2'd1);
    total_cnt++; if (a_req_intid !== 2'd2) $display("FAIL same_no_reuse got_intid=%0d exp=2", a_req_intid); else pass_cnt++;
    cycle();
    a_drive(1'b0, 2'd1, 1'b0, 2'd0);
    total_cnt++; if ({a_req_ready, a_req_intid} !== 3'b1_01) $display("FAIL same_freed got=%b/%0d exp=1/1", a_req_ready, a_req_intid); else pass_cnt++;
    total_cnt++; if (a_cpl_err !== 1'b0) $display("FAIL same_cpl_err got=%b exp=0", a_cpl_err); else pass_cnt++;
  endtask

  task automatic test_cpl_err();
    a_reset();
    a_drive(1'b1, 2'd0, 1'b0, 2'd0); cycle();
    a_drive(1'b1, 2'd1, 1'b0, 2'd0); cycle();
    a_drive(1'b0, 2'd0, 1'b1, 2'd2);
    cycle();
    a_drive(1'b0, 2'd0, 1'b0, 2'd0);
    total_cnt++; if (a_cpl_err !== 1'b1) $display("FAIL err_pulse got=%b exp=1", a_cpl_err); else pass_cnt++;
    total_cnt++; if ({a_req_ready, a_req_intid} !== 3'b1_00) $display("FAIL err_hit0 got=%b/%0d exp=1/0", a_req_ready, a_req_intid); else pass_cnt++;
    cycle();
    a_drive(1'b0, 2'd3, 1'b0, 2'd0);
    total_cnt++; if (a_cpl_err !== 1'b0) $display("FAIL err_one_cycle got=%b exp=0", a_cpl_err); else pass_cnt++;
    total_cnt++; if ({a_req_ready, a_req_intid} !== 3'b1_10) $display("FAIL err_no_change got=%b/%0d exp=1/2", a_req_ready, a_req_intid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    a_reset();
    for (int i = 0; i < 3; i++) begin
      a_drive(1'b1, 2'(i), 1'b0, 2'd0); cycle();
    end
    a_rst = 1'b1;
    a_drive(1'b1, 2'd3, 1'b1, 2'd3);
    cycle();
    a_rst = 1'b0;
    a_drive(1'b0, 2'd3, 1'b0, 2'd0);
    total_cnt++; if (a_empty !== 1'b1) $display("FAIL rstmid_empty got=%b exp=1", a_empty); else pass_cnt++;
    total_cnt++; if (a_cpl_err !== 1'b0) $display("FAIL rstmid_cpl_err got=%b exp=0", a_cpl_err); else pass_cnt++;
    total_cnt++; if ({a_req_ready, a_req_intid} !== 3'b1_00) $display("FAIL rstmid_grant got=%b/%0d exp=1/0", a_req_ready, a_req_intid); else pass_cnt++;
  endtask

  task automatic test_full_miss();
    b_rst = 1'b1;
    b_req_valid = 1'b0; b_req_id = 3'd0; b_cpl_valid = 1'b0; b_cpl_intid = 2'd0;
    cycle();
    b_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_req_valid = 1'b1; b_req_id = 3'(i);
      cycle();
    end
    b_req_valid = 1'b1; b_req_id = 3'd5;
    #1;
    total_cnt++; if (b_full !== 1'b1) $display("FAIL wide_full got=%b exp=1", b_full); else pass_cnt++;
    total_cnt++; if ({b_req_ready, b_req_intid} !== 3'b0_00) $display("FAIL wide_miss_full got=%b/%0d exp=0/0", b_req_ready, b_req_intid); else pass_cnt++;
    cycle();
    b_req_valid = 1'b0; b_req_id = 3'd2;
    #1;
    total_cnt++; if ({b_req_ready, b_req_intid} !== 3'b1_10) $display("FAIL wide_hit got=%b/%0d exp=1/2", b_req_ready, b_req_intid); else pass_cnt++;
  endtask

  initial begin
    a_rst = 1'b1; a_req_valid = 1'b0; a_req_id = '0; a_cpl_valid = 1'b0; a_cpl_intid = '0;
    b_rst = 1'b1; b_req_valid = 1'b0; b_req_id = '0; b_cpl_valid = 1'b0; b_cpl_intid = '0;
    cycle();
    test_reset();
    test_first_alloc();
    test_fill();
    test_saturate();
    test_same_cycle();
    test_cpl_err();
    test_reset_mid();
    test_full_miss();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_mon_id_alloc.md
Name: axi_mon_id_alloc

Overview:
- Allocates internal IDs for the AXI monitor: maps each incoming master ID (IdWidth bits) onto one of MaxUniqIds internal slots (IntIdWidth bits).
- Counts outstanding transactions per slot and frees a slot when its last transaction completes.
- Sits between the monitored AXI request channel (AW or AR) and the per-ID timeout/tracking logic; one instance per direction.
- The response path uses it to translate internal IDs back to master IDs.

Parameters:
- MaxUniqIds, 4, number of internal ID slots (≥1).
- MaxTxnsPerId, 256, maximum outstanding transactions per slot (≥1).
- IdWidth, 2, master-side ID width.
- IntIdWidth, (MaxUniqIds>1)?$clog2(MaxUniqIds):1, internal ID width; derived, do not override.
- CntW, $clog2(MaxTxnsPerId+1), per-slot counter width; derived.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  new transaction request (AW/AR handshake observed)
- req_id_i  in  IdWidth  master ID of the request
- req_ready_o  out  1  allocator can accept the request this cycle
- req_intid_o  out  IntIdWidth  granted slot; valid when req_valid_i && req_ready_o
- cpl_valid_i  in  1  transaction completion (last B / last R)
- cpl_intid_i  in  IntIdWidth  slot of the completing transaction
- cpl_id_o  out  IdWidth  master ID stored in slot cpl_intid_i (combinational lookup)
- cpl_err_o  out  1  one-cycle pulse: completion hit an empty slot
- full_o  out  1  all slots valid
- empty_o  out  1  no slot valid

Behaviour:
- State per slot: valid bit, id (IdWidth), cnt (CntW).
- Reset (rst_i=1 at a clk_i edge): all valid=0, cnt=0, id=0; cpl_err_o=0. Reset dominates any request/completion in the same cycle; in-flight tracking is lost.
- Lookup (combinational, current state only):
  - hit = some valid slot has id == req_id_i. IDs are unique across valid slots by construction.
  - If hit: req_ready_o = (cnt < MaxTxnsPerId); req_intid_o = hit slot.
  - If miss: req_ready_o = any slot invalid; req_intid_o = lowest-index invalid slot.
  - When req_ready_o=0, req_intid_o=0.
- req_ready_o depends only on registered state and req_id_i, never on req_valid_i. The allocator cannot backpressure the bus; the integrator uses it to gate or flag. Zero-cycle latency: grant in the same cycle, state updates at the next edge.
- Accept (req_valid_i && req_ready_o):
  - Hit: cnt += 1.
  - Miss: slot becomes valid, id = req_id_i, cnt = 1.
- Completion (cpl_valid_i):
  - Slot cpl_intid_i valid: cnt -= 1; at cnt==0 the slot becomes invalid next cycle (id is retained but irrelevant).
  - Slot invalid, or index ≥ MaxUniqIds: no state change; cpl_err_o=1 in the next cycle (registered, one cycle).
- Simultaneous accept and completion on the same slot: cnt is unchanged, and the slot stays valid even at cnt==1.
- A slot freed by a completion this cycle cannot be allocated in the same cycle. The miss path uses pre-update state, so a different ID is granted that slot the following cycle at the earliest.
- Saturation: cnt never exceeds MaxTxnsPerId (guarded by req_ready_o) and never underflows (guarded by the valid check).
- cpl_id_o = id[cpl_intid_i] regardless of valid. It is meaningful only when that slot is valid.
- full_o / empty_o are combinational from the registered valid bits.

Test Plan:
- Reset, then req id=2 → ready=1, intid=0; next cycle slot0 valid, cnt=1, empty_o=0.
- Reqs for ids 0,1,2,3 → intids 0..3, full_o=1. Req id=1 → ready=1, intid=1. Req with no matching ID while full: not reachable with IdWidth=2, so rerun with IdWidth=3 and id=5 → ready=0.
- MaxTxnsPerId=256: 256 accepted reqs id=1 → 257th has ready=0. One completion intid=0 → next cycle ready=1.
- Slot1 cnt=1, same cycle req id=3 (slot1's id) + cpl intid=1 → slot1 stays valid, cnt=1. Repeat with cpl only → slot1 invalid next cycle.
- Completion intid=2 while slot2 empty → cpl_err_o=1 for exactly one cycle, no state change.
- 3 slots valid, rst_i asserted mid-stream with req_valid_i=1 → next cycle all slots invalid, empty_o=1, cpl_err_o=0.
